// File: rtl/store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer_unit
// Purpose : FIFO store buffer with lane steering and load-hazard detection;
//           optional tail-entry store merging under STORE_MERGE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module store_buffer_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_funct3,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_err,
  output logic                     mem_we,
  output logic [AW-3:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int           PW     = $clog2(DEPTH);
  localparam logic [PW:0]  C_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]  C_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] C_PINC = PW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  logic [AW-3:0]  r_addr [DEPTH];
  logic [31:0]    r_data [DEPTH];
  logic [3:0]     r_be   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]  r_head, r_tail;
  logic [PW:0]    r_count;
  logic           r_err;
  state_t         r_state, w_state_nxt;

  logic [1:0]     w_off;
  logic           w_legal;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;
  logic [PW-1:0]  w_tail_last;
  logic           w_full, w_merge, w_accept, w_push, w_pop, w_hit;
  logic           w_unused;

  assign w_off       = st_addr[1:0];
  assign w_tail_last = r_tail - C_PINC;
  assign w_full      = (r_count == C_FULL);
  assign w_unused    = ^ld_addr[1:0];

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = st_data;
    case (st_funct3)
      3'b000: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        w_legal = !w_off[0];
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{st_data[15:0]}};
      end
      3'b010: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef STORE_MERGE_EN
  // The head cannot absorb a merge in the cycle memory is consuming it.
  assign w_merge  = w_legal && (r_count != '0)
                 && (r_addr[w_tail_last] == st_addr[AW-1:2])
                 && !((r_count == C_ONE) && mem_ack);
  assign st_ready = !w_full || w_merge;
`else
  assign w_merge  = 1'b0;
  assign st_ready = !w_full;
`endif

  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && w_legal && !w_merge;
  assign w_pop    = mem_ack && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_err   <= w_accept && !w_legal;
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + C_PINC;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + C_PINC;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: r_valid and r_count gate every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr[AW-1:2];
      r_data[r_tail] <= w_wdata;
      r_be[r_tail]   <= w_be;
    end else if (w_accept && w_merge) begin
      r_be[w_tail_last] <= r_be[w_tail_last] | w_be;
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_data[w_tail_last][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_count == C_ONE) && w_pop && !w_push) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == ld_addr[AW-1:2])) w_hit = 1'b1;
    end
  end

  assign ld_hit    = w_hit;
  assign st_err    = r_err;
  assign mem_we    = (r_state == S_DRAIN);
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_be    = r_be[r_head];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_buffer_unit
// Purpose : Queue-model bench for store_buffer_unit (honours STORE_MERGE_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_store_buffer_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, st_ready, st_err, mem_we, mem_ack, ld_hit;
  logic [2:0]    st_funct3;
  logic [AW-1:0] st_addr, ld_addr;
  logic [31:0]   st_data, mem_wdata;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [2:0]    count;

  store_buffer_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_err(st_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic exp_err = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [2:0] f, input logic [1:0] o);
    if (f == 3'd0) return 1'b1;
    if (f == 3'd1) return (o % 2) == 0;
    if (f == 3'd2) return o == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f, input logic [1:0] o);
    if (f == 3'd0) return 4'(1 << o);
    if (f == 3'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'd0) return {4{d[7:0]}};
    if (f == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic tail_match();
`ifdef STORE_MERGE_EN
    if (q.size() == 0 || !is_legal(st_funct3, st_addr[1:0])) return 1'b0;
    if (q.size() == 1 && mem_ack) return 1'b0;
    return q[$].wa == st_addr[31:2];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_ready();
    return (q.size() != DEPTH) || tail_match();
  endfunction

  task automatic compare();
    logic hit;
    hit = 1'b0;
    foreach (q[i]) if (q[i].wa == ld_addr[31:2]) hit = 1'b1;
    chk("st_ready", st_ready, model_ready());
    chk("count", count, q.size());
    chk("mem_we", mem_we, q.size() != 0);
    chk("ld_hit", ld_hit, hit);
    chk("st_err", st_err, exp_err);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].wa);
      chk("mem_wdata", mem_wdata, q[0].d);
      chk("mem_be", mem_be, q[0].be);
    end
  endtask

  task automatic update();
    logic acc, lg, m;
    logic [3:0] nb;
    logic [31:0] nd;
    ent_t e;
    acc = st_valid && model_ready();
    lg  = is_legal(st_funct3, st_addr[1:0]);
    m   = tail_match();
    nb  = lane_be(st_funct3, st_addr[1:0]);
    nd  = lane_data(st_funct3, st_data);
    exp_err = acc && !lg;
    if (mem_ack && q.size() != 0) void'(q.pop_front());
    if (acc && lg) begin
      if (m) begin
        for (int b = 0; b < 4; b++) if (nb[b]) q[$].d[8*b +: 8] = nd[8*b +: 8];
        q[$].be = q[$].be | nb;
      end else begin
        e.wa = st_addr[31:2]; e.d = nd; e.be = nb;
        q.push_back(e);
      end
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic ack, input logic [31:0] la);
    st_valid = v; st_funct3 = f; st_addr = a; st_data = d; mem_ack = ack; ld_addr = la;
    #2;
    compare();
    update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'd0; st_addr = '0; st_data = '0;
    mem_ack = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_st_err", st_err, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_st_ready", st_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Byte store to the top lane, then drain.
    step(1, 3'd0, 32'h103, 32'h000000AB, 0, 0);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 30'h40);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    step(0, 3'd0, 0, 0, 1, 0);
    chk("sb_drained_count", count, 0);
    chk("sb_drained_we", mem_we, 0);

    // SH then SW, drained in order.
    step(1, 3'd1, 32'h202, 32'h00001234, 0, 0);
    step(1, 3'd2, 32'h300, 32'hDEADBEEF, 0, 0);
    chk("shsw_count", count, 2);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    step(0, 3'd0, 0, 0, 1, 0);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_addr", mem_addr, 30'hC0);
    step(0, 3'd0, 0, 0, 1, 0);
    chk("shsw_empty", count, 0);

    // Fill to full, refused 5th store, simultaneous push/pop at count 3.
    for (int i = 0; i < 4; i++) step(1, 3'd2, 32'h400 + 32'(4*i), $urandom, 0, 0);
    chk("full_count", count, 4);
`ifndef STORE_MERGE_EN
    chk("full_ready", st_ready, 0);
`endif
    step(1, 3'd2, 32'h500, 32'h55555555, 0, 0);
    chk("full_refused", count, 4);
    step(0, 3'd0, 0, 0, 1, 0);
    step(1, 3'd2, 32'h600, 32'h66666666, 1, 0);
    chk("pushpop_count", count, 3);
    for (int i = 0; i < 4; i++) step(0, 3'd0, 0, 0, 1, 0);
    chk("wrap_empty", count, 0);

    // Misaligned and illegal-funct3 stores.
    step(1, 3'd2, 32'h102, 32'h1, 0, 0);
    chk("mis_err", st_err, 1);
    chk("mis_count", count, 0);
    step(1, 3'd3, 32'h100, 32'h1, 0, 0);
    chk("f3_err", st_err, 1);
    chk("f3_we", mem_we, 0);
    step(0, 3'd0, 0, 0, 0, 0);
    chk("err_pulse_end", st_err, 0);

    // Load hazard.
    step(1, 3'd0, 32'h104, 32'h55, 0, 32'h107);
    ld_addr = 32'h107; #1;
    chk("hit_same_word", ld_hit, 1);
    ld_addr = 32'h108; #1;
    chk("hit_next_word", ld_hit, 0);
    step(0, 3'd0, 0, 0, 1, 32'h107);
    ld_addr = 32'h107; #1;
    chk("hit_after_drain", ld_hit, 0);

`ifdef STORE_MERGE_EN
    step(1, 3'd0, 32'h100, 32'h11, 0, 0);
    step(1, 3'd0, 32'h101, 32'h22, 0, 0);
    chk("merge_count", count, 1);
    chk("merge_be", mem_be, 4'b0011);
    chk("merge_wdata", mem_wdata[15:0], 16'h2211);
    step(0, 3'd0, 0, 0, 1, 0);
`endif

    // Reset mid-drain discards everything.
    for (int i = 0; i < 3; i++) step(1, 3'd2, 32'h700 + 32'(4*i), $urandom, 0, 0);
    st_valid = 1'b0; mem_ack = 1'b1;
    rst = 1'b1; #1;
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_count", count, 0);
    q.delete(); exp_err = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 3'd0, 0, 0, 1, 32'h700);

    // Randomised traffic over a few words so hits, fills and merges recur.
    for (int n = 0; n < 500; n++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 2) != 0, f,
           32'h100 + 32'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 4,
           32'h100 + 32'($urandom_range(0, 15)));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 3'd0, 0, 0, 1, 0);
    chk("final_empty", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
